reorder_buffer: RTL

- Circular in-order reorder buffer between the dispatcher, the execution units' common data bus (CDB) and the register file.
- Allocates one entry per dispatched instruction and captures results from the CDB.
- Retires at most one entry per cycle from the head: writes back to the register file, releases stores to the load/store buffer, and resolves branches.
- A branch mispredict flushes the whole machine.

---
 rtl/reorder_buffer_pkg.sv | 35 +++
 rtl/rob_operand_query.sv | 36 +++
 rtl/reorder_buffer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared ROB definitions: sizes, entry type encodings
// and tag/index helpers used by the buffer and its query ports.
package reorder_buffer_pkg;

  localparam int ROB_SIZE   = 16;
  localparam int TAG_W      = 5;
  localparam int IDX_W      = 4;
  localparam int DATA_WIDTH = 32;

  localparam logic [TAG_W-1:0] NON_DEPENDENT = '0;

  typedef enum logic [1:0] {
    ROB_REG    = 2'd0,
    ROB_STORE  = 2'd1,
    ROB_BRANCH = 2'd2,
    ROB_EXIT   = 2'd3
  } rob_type_e;

  // Tags are entry index + 1 so that 0 can mean "no producer".
  function automatic logic [IDX_W-1:0] tag2idx(
    input logic [TAG_W-1:0] t
  );
    logic [TAG_W-1:0] m;
    m = t - TAG_W'(1);
    return m[IDX_W-1:0];
  endfunction

  function automatic logic tag_live(
    input logic [TAG_W-1:0] t
  );
    return (t != NON_DEPENDENT) &&
           (t <= TAG_W'(ROB_SIZE));
  endfunction

endpackage

// File: rtl/rob_operand_query.sv
// Operand lookup for the dispatcher: entry value with CDB bypass.
// Ports: i_tag query, entry busy/ready/value arrays, CDB, o_ready/o_value.
module rob_operand_query
  import reorder_buffer_pkg::*;
(
  input  logic [TAG_W-1:0]                    i_tag,
  input  logic [ROB_SIZE-1:0]                 i_busy,
  input  logic [ROB_SIZE-1:0]                 i_ready,
  input  logic [ROB_SIZE-1:0][DATA_WIDTH-1:0] i_value,
  input  logic                                i_cdb_en,
  input  logic [TAG_W-1:0]                    i_cdb_tag,
  input  logic [DATA_WIDTH-1:0]               i_cdb_value,
  output logic                                o_ready,
  output logic [DATA_WIDTH-1:0]               o_value
);

  logic [IDX_W-1:0] w_idx;
  assign w_idx = tag2idx(i_tag);

  always_comb begin
    o_ready = 1'b0;
    o_value = '0;
    if (i_tag != NON_DEPENDENT) begin
      // A broadcast this cycle beats the stored copy.
      if (i_cdb_en && (i_cdb_tag == i_tag)) begin
        o_ready = 1'b1;
        o_value = i_cdb_value;
      end else if (tag_live(i_tag) &&
                   i_busy[w_idx] && i_ready[w_idx]) begin
        o_ready = 1'b1;
        o_value = i_value[w_idx];
      end
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocate at tail, complete from CDB,
// retire one entry per cycle at head (reg write, store release, branch
// resolve, exit). Ports: dispatcher alloc/query, CDB, commit/flush outputs.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  alloc_en,
  input  logic [1:0]            alloc_type,
  input  logic [4:0]            alloc_rd,
  input  logic                  alloc_pred_taken,
  input  logic [31:0]           alloc_pc_alt,
  output logic [TAG_W-1:0]      alloc_tag,
  output logic                  full,
  input  logic [TAG_W-1:0]      qj_tag,
  input  logic [TAG_W-1:0]      qk_tag,
  output logic                  qj_ready,
  output logic                  qk_ready,
  output logic [DATA_WIDTH-1:0] qj_value,
  output logic [DATA_WIDTH-1:0] qk_value,
  input  logic                  cdb_en,
  input  logic [TAG_W-1:0]      cdb_tag,
  input  logic [DATA_WIDTH-1:0] cdb_value,
  input  logic                  cdb_taken,
  output logic                  commit_en,
  output logic [4:0]            commit_rd,
  output logic [TAG_W-1:0]      commit_tag,
  output logic [DATA_WIDTH-1:0] commit_value,
  output logic                  store_commit,
  output logic                  mispredict,
  output logic [31:0]           redirect_pc,
  output logic                  halt
);

  localparam logic [IDX_W:0] CNT_FULL = (IDX_W+1)'(ROB_SIZE);

  logic [IDX_W-1:0] r_head;
  logic [IDX_W-1:0] r_tail;
  logic [IDX_W:0]   r_count;

  logic [ROB_SIZE-1:0]                 r_busy;
  logic [ROB_SIZE-1:0]                 r_ready;
  logic [ROB_SIZE-1:0]                 r_pred;
  logic [ROB_SIZE-1:0]                 r_taken;
  logic [ROB_SIZE-1:0][1:0]            r_type;
  logic [ROB_SIZE-1:0][4:0]            r_rd;
  logic [ROB_SIZE-1:0][31:0]           r_pc_alt;
  logic [ROB_SIZE-1:0][DATA_WIDTH-1:0] r_value;

  logic                  r_commit_en;
  logic [4:0]            r_commit_rd;
  logic [TAG_W-1:0]      r_commit_tag;
  logic [DATA_WIDTH-1:0] r_commit_value;
  logic                  r_store_commit;
  logic                  r_mispredict;
  logic [31:0]           r_redirect_pc;
  logic                  r_halt;

  logic             w_full;
  logic [IDX_W-1:0] w_cdb_idx;
  logic             w_cdb_hit;
  logic             w_do_alloc;
  logic             w_do_commit;
  logic             w_flush;
  logic             w_hd_reg;
  logic             w_hd_store;
  logic             w_hd_branch;
  logic             w_hd_exit;

  assign w_full      = (r_count == CNT_FULL);
  assign w_cdb_idx   = tag2idx(cdb_tag);
  assign w_cdb_hit   = cdb_en && tag_live(cdb_tag) &&
                       r_busy[w_cdb_idx];
  assign w_do_alloc  = alloc_en && !w_full;
  assign w_do_commit = !r_halt && r_busy[r_head] &&
                       r_ready[r_head];

  assign w_hd_reg    = (r_type[r_head] == ROB_REG);
  assign w_hd_store  = (r_type[r_head] == ROB_STORE);
  assign w_hd_branch = (r_type[r_head] == ROB_BRANCH);
  assign w_hd_exit   = (r_type[r_head] == ROB_EXIT);

  assign w_flush = w_do_commit && w_hd_branch &&
                   (r_taken[r_head] != r_pred[r_head]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_busy         <= '0;
      r_ready        <= '0;
      r_pred         <= '0;
      r_taken        <= '0;
      r_type         <= '0;
      r_rd           <= '0;
      r_pc_alt       <= '0;
      r_value        <= '0;
      r_commit_en    <= 1'b0;
      r_commit_rd    <= '0;
      r_commit_tag   <= '0;
      r_commit_value <= '0;
      r_store_commit <= 1'b0;
      r_mispredict   <= 1'b0;
      r_redirect_pc  <= '0;
      r_halt         <= 1'b0;
    end else if (rdy) begin
      r_commit_en    <= 1'b0;
      r_store_commit <= 1'b0;
      r_mispredict   <= 1'b0;
      if (r_mispredict) begin
        // Flush bubble: upstream is also flushing, drop everything.
      end else if (w_flush) begin
        r_head        <= '0;
        r_tail        <= '0;
        r_count       <= '0;
        r_busy        <= '0;
        r_ready       <= '0;
        r_mispredict  <= 1'b1;
        r_redirect_pc <= r_pc_alt[r_head];
      end else begin
        if (w_cdb_hit) begin
          r_ready[w_cdb_idx] <= 1'b1;
          r_value[w_cdb_idx] <= cdb_value;
          r_taken[w_cdb_idx] <= cdb_taken;
        end
        if (w_do_commit) begin
          r_busy[r_head]  <= 1'b0;
          r_ready[r_head] <= 1'b0;
          r_head          <= r_head + IDX_W'(1);
          unique case (1'b1)
            w_hd_reg: begin
              r_commit_en    <= 1'b1;
              r_commit_rd    <= r_rd[r_head];
              r_commit_tag   <= TAG_W'(r_head) + TAG_W'(1);
              r_commit_value <= r_value[r_head];
            end
            w_hd_store:  r_store_commit <= 1'b1;
            w_hd_branch: ;
            w_hd_exit:   r_halt <= 1'b1;
          endcase
        end
        // Fresh allocation wins over a same-edge CDB write to tail.
        if (w_do_alloc) begin
          r_busy[r_tail]   <= 1'b1;
          r_ready[r_tail]  <= 1'b0;
          r_type[r_tail]   <= alloc_type;
          r_rd[r_tail]     <= alloc_rd;
          r_pred[r_tail]   <= alloc_pred_taken;
          r_pc_alt[r_tail] <= alloc_pc_alt;
          r_tail           <= r_tail + IDX_W'(1);
        end
        r_count <= r_count
                 + (IDX_W+1)'(w_do_alloc)
                 - (IDX_W+1)'(w_do_commit);
      end
    end
  end

  rob_operand_query u_qj (
    .i_tag       (qj_tag),
    .i_busy      (r_busy),
    .i_ready     (r_ready),
    .i_value     (r_value),
    .i_cdb_en    (cdb_en),
    .i_cdb_tag   (cdb_tag),
    .i_cdb_value (cdb_value),
    .o_ready     (qj_ready),
    .o_value     (qj_value)
  );

  rob_operand_query u_qk (
    .i_tag       (qk_tag),
    .i_busy      (r_busy),
    .i_ready     (r_ready),
    .i_value     (r_value),
    .i_cdb_en    (cdb_en),
    .i_cdb_tag   (cdb_tag),
    .i_cdb_value (cdb_value),
    .o_ready     (qk_ready),
    .o_value     (qk_value)
  );

  assign alloc_tag    = TAG_W'(r_tail) + TAG_W'(1);
  assign full         = w_full;
  assign commit_en    = r_commit_en;
  assign commit_rd    = r_commit_rd;
  assign commit_tag   = r_commit_tag;
  assign commit_value = r_commit_value;
  assign store_commit = r_store_commit;
  assign mispredict   = r_mispredict;
  assign redirect_pc  = r_redirect_pc;
  assign halt         = r_halt;

endmodule
